packet_engine_scheduler: RTL and testbench

//  Sequences rx packets through the protocol engines (ARP, ICMP, IPbus/UDP).

---
 rtl/packet_engine_scheduler_pkg.sv | 20 ++
 rtl/packet_engine_scheduler_engine_port_mux.sv | 33 +++
 rtl/packet_engine_scheduler.sv | 131 +++++++++++++
 tb/tb_packet_engine_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_engine_scheduler_pkg.sv
// rtl/packet_engine_scheduler_pkg.sv - shared types and constants for the packet engine scheduler
package packet_engine_scheduler_pkg;

    localparam int DEFAULT_ADDR_W = 11;

    localparam int ENG_ARP   = 0;
    localparam int ENG_ICMP  = 1;
    localparam int ENG_IPBUS = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_OFFER    = 3'd1,
        ST_WAIT     = 3'd2,
        ST_RELEASE  = 3'd3,
        ST_NEXT     = 3'd4,
        ST_TX_START = 3'd5,
        ST_FREE     = 3'd6
    } sched_state_t;

endpackage

// File: rtl/packet_engine_scheduler_engine_port_mux.sv
// rtl/packet_engine_scheduler_engine_port_mux.sv - one-hot grant mux of engine buffer ports
module engine_port_mux
    import packet_engine_scheduler_pkg::*;
#(
    parameter int N_ENG  = 3,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic [N_ENG-1:0]        grant,
    input  logic [N_ENG*ADDR_W-1:0] eng_read_addr,
    input  logic [N_ENG*8-1:0]      eng_out,
    input  logic [N_ENG*ADDR_W-1:0] eng_out_addr,
    input  logic [N_ENG-1:0]        eng_out_we,
    output logic [ADDR_W-1:0]       rx_read_addr,
    output logic [7:0]              tx_data,
    output logic [ADDR_W-1:0]       tx_addr,
    output logic                    tx_we
);

    // AND-OR mux: grant is one-hot, so an empty grant yields all zeros
    always_comb begin
        rx_read_addr = '0;
        tx_data      = '0;
        tx_addr      = '0;
        tx_we        = 1'b0;
        for (int i = 0; i < N_ENG; i++) begin
            rx_read_addr = rx_read_addr | (eng_read_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{grant[i]}});
            tx_data      = tx_data      | (eng_out[i*8 +: 8] & {8{grant[i]}});
            tx_addr      = tx_addr      | (eng_out_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{grant[i]}});
            tx_we        = tx_we        | (eng_out_we[i] & grant[i]);
        end
    end

endmodule

// File: rtl/packet_engine_scheduler.sv
// rtl/packet_engine_scheduler.sv - offers each rx packet to the protocol engines in priority order
module packet_engine_scheduler
    import packet_engine_scheduler_pkg::*;
#(
    parameter int N_ENG   = 3,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int TIMEOUT = 4095
) (
    input  logic                    mac_clk,
    input  logic                    reset,
    input  logic                    rx_ready,
    output logic                    rx_done,
    output logic [ADDR_W-1:0]       rx_read_addr,
    output logic [N_ENG-1:0]        eng_ready,
    input  logic [N_ENG-1:0]        eng_done,
    input  logic [N_ENG-1:0]        eng_xmit,
    input  logic [N_ENG*ADDR_W-1:0] eng_read_addr,
    input  logic [N_ENG*8-1:0]      eng_out,
    input  logic [N_ENG*ADDR_W-1:0] eng_out_addr,
    input  logic [N_ENG-1:0]        eng_out_we,
    output logic [7:0]              tx_data,
    output logic [ADDR_W-1:0]       tx_addr,
    output logic                    tx_we,
    output logic                    tx_start,
    input  logic                    tx_busy,
    output logic [15:0]             drop_count,
    output logic                    timeout_seen
);

    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int IDX_W = (N_ENG > 1) ? $clog2(N_ENG) : 1;
    localparam logic [TMR_W-1:0] TIMEOUT_V = TMR_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_ENG - 1);

    sched_state_t     state;
    logic [IDX_W-1:0] idx;
    logic [TMR_W-1:0] timer;
    logic [N_ENG-1:0] grant;
    logic             xmit;

    engine_port_mux #(
        .N_ENG (N_ENG),
        .ADDR_W(ADDR_W)
    ) u_mux (
        .grant        (grant),
        .eng_read_addr(eng_read_addr),
        .eng_out      (eng_out),
        .eng_out_addr (eng_out_addr),
        .eng_out_we   (eng_out_we),
        .rx_read_addr (rx_read_addr),
        .tx_data      (tx_data),
        .tx_addr      (tx_addr),
        .tx_we        (tx_we)
    );

    always_ff @(posedge mac_clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            idx          <= '0;
            timer        <= '0;
            grant        <= '0;
            xmit         <= 1'b0;
            eng_ready    <= '0;
            rx_done      <= 1'b0;
            tx_start     <= 1'b0;
            drop_count   <= '0;
            timeout_seen <= 1'b0;
        end else begin
            rx_done  <= 1'b0;
            tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // the MAC owns the tx buffer while busy, so no engine may start a reply
                    if (rx_ready && !tx_busy) begin
                        idx   <= IDX_W'(ENG_ARP);
                        state <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    grant     <= N_ENG'(1) << idx;
                    eng_ready <= N_ENG'(1) << idx;
                    timer     <= '0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eng_done[idx]) begin
                        eng_ready <= '0;
                        xmit      <= eng_xmit[idx];
                        state     <= ST_RELEASE;
                    end else if (timer == TIMEOUT_V) begin
                        // a hung engine is treated as a decline and loses the grant at once
                        eng_ready    <= '0;
                        grant        <= '0;
                        xmit         <= 1'b0;
                        timeout_seen <= 1'b1;
                        state        <= ST_NEXT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!eng_done[idx]) begin
                        grant <= '0;
                        state <= xmit ? ST_TX_START : ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (idx == LAST_IDX) begin
                        if (drop_count != 16'hFFFF) begin
                            drop_count <= drop_count + 1'b1;
                        end
                        state <= ST_FREE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_OFFER;
                    end
                end
                ST_TX_START: begin
                    tx_start <= 1'b1;
                    state    <= ST_FREE;
                end
                ST_FREE: begin
                    rx_done <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_engine_scheduler.sv
// tb/tb_packet_engine_scheduler.sv - self-checking bench for packet_engine_scheduler
module tb_packet_engine_scheduler;
    import packet_engine_scheduler_pkg::*;

    localparam int N_ENG   = 3;
    localparam int ADDR_W  = 11;
    localparam int TIMEOUT = 63;
    localparam int M_DEC = 0, M_REP = 1, M_HANG = 2, M_STREAM = 3;

    logic                    mac_clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    rx_ready = 1'b0;
    logic                    tx_busy = 1'b0;
    logic                    rx_done, tx_we, tx_start, timeout_seen;
    logic [ADDR_W-1:0]       rx_read_addr, tx_addr;
    logic [7:0]              tx_data;
    logic [N_ENG-1:0]        eng_ready, eng_done, eng_xmit, eng_out_we;
    logic [N_ENG*ADDR_W-1:0] eng_read_addr, eng_out_addr;
    logic [N_ENG*8-1:0]      eng_out;
    logic [15:0]             drop_count;

    packet_engine_scheduler #(.N_ENG(N_ENG), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .mac_clk      (mac_clk),
        .reset        (reset),
        .rx_ready     (rx_ready),
        .rx_done      (rx_done),
        .rx_read_addr (rx_read_addr),
        .eng_ready    (eng_ready),
        .eng_done     (eng_done),
        .eng_xmit     (eng_xmit),
        .eng_read_addr(eng_read_addr),
        .eng_out      (eng_out),
        .eng_out_addr (eng_out_addr),
        .eng_out_we   (eng_out_we),
        .tx_data      (tx_data),
        .tx_addr      (tx_addr),
        .tx_we        (tx_we),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .drop_count   (drop_count),
        .timeout_seen (timeout_seen)
    );

    always #5 mac_clk = ~mac_clk;

    int cyc = 0;
    always @(posedge mac_clk) cyc <= cyc + 1;

    typedef struct {
        int m0, m1, m2;
        int dly;
        int busy;
        bit stray;
        int n_off;
        int n_tx;
        int drop_inc;
        bit to;
    } vec_t;

    vec_t vecs[7];

    int n_cmp = 0, n_err = 0;
    int exp_offer_q[$];
    logic [ADDR_W+7:0] tx_q[$];
    int cfg_mode[N_ENG];
    int cfg_dly;
    bit cfg_stray;
    int tx_start_cnt, rx_done_cnt, offer_lat, rx_cyc, done_fall_cyc;
    bit first_rise_pending = 1'b0, busy_window = 1'b0, busy_violation;
    int rise_cyc[N_ENG];
    logic [15:0] exp_drop;
    bit exp_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_eng_ready"}, 32'(eng_ready), 0);
        check({tag, "_pulses"}, {28'd0, rx_done, tx_start, tx_we, timeout_seen}, 0);
        check({tag, "_rx_read_addr"}, 32'(rx_read_addr), 0);
        check({tag, "_tx_data_addr"}, {13'd0, tx_addr, tx_data}, 0);
        check({tag, "_drop_count"}, 32'(drop_count), 0);
    endtask

    // Behavioural protocol engine; only the engine seeing eng_ready acts
    task automatic serve(input int i);
        int mode;
        int guard;
        mode = cfg_mode[i];
        for (int k = 0; k < cfg_dly; k++) begin
            @(posedge mac_clk); #1;
            if (reset) return;
            if (cfg_stray && i == 0 && k == 2) begin
                eng_done[2] = 1'b1; eng_xmit[2] = 1'b1; eng_out_we[2] = 1'b1; eng_out[16 +: 8] = 8'hEE;
            end
            if (cfg_stray && i == 0 && k == 5) begin
                eng_done[2] = 1'b0; eng_xmit[2] = 1'b0; eng_out_we[2] = 1'b0; eng_out[16 +: 8] = 8'hA2;
            end
        end
        if (mode == M_HANG) begin
            guard = 0;
            while (eng_ready[i] && !reset && guard < TIMEOUT + 20) begin
                @(posedge mac_clk); #1; guard++;
            end
            return;
        end
        if (mode == M_STREAM || mode == M_REP) begin
            guard = 0;
            while (!reset && eng_ready[i] && guard < ((mode == M_REP) ? 4 : 200)) begin
                eng_out_we[i] = 1'b1;
                eng_out_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(i*64 + guard + 1);
                eng_out[i*8 +: 8] = 8'(i*16 + guard + 1);
                tx_q.push_back({ADDR_W'(i*64 + guard + 1), 8'(i*16 + guard + 1)});
                @(posedge mac_clk); #1; guard++;
            end
            eng_out_we[i] = 1'b0;
            if (reset || mode == M_STREAM) return;
        end
        eng_done[i] = 1'b1;
        eng_xmit[i] = (mode == M_REP);
        guard = 0;
        do begin
            @(posedge mac_clk); #1; guard++;
        end while (eng_ready[i] && !reset && guard < 200);
        eng_done[i] = 1'b0;
        eng_xmit[i] = 1'b0;
        done_fall_cyc = cyc;
    endtask

    initial begin
        eng_done = '0; eng_xmit = '0; eng_out_we = '0;
        for (int i = 0; i < N_ENG; i++) begin
            eng_read_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(i*100 + 5);
            eng_out_addr[i*ADDR_W +: ADDR_W]  = ADDR_W'(12'h700 + i);
            eng_out[i*8 +: 8]                 = 8'(8'hA0 + i);
        end
        forever begin
            @(posedge mac_clk); #1;
            if (!reset) begin
                for (int i = 0; i < N_ENG; i++) if (eng_ready[i]) serve(i);
            end
        end
    end

    // Output monitor and scoreboard consumer, sampling on the falling edge
    initial begin
        logic [N_ENG-1:0] prev_ready;
        prev_ready = '0;
        forever begin
            @(negedge mac_clk);
            if (reset) begin
                prev_ready = '0;
                continue;
            end
            if (tx_we) begin
                if (tx_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL tx_we_unexpected: got addr %0h data %0h, required no write (cycle %0d)", tx_addr, tx_data, cyc);
                end else begin
                    check("tx_write", {13'd0, tx_addr, tx_data}, {13'd0, tx_q.pop_front()});
                end
            end
            if (tx_start) begin
                tx_start_cnt++;
                check("tx_start_latency", cyc - done_fall_cyc, 2);
            end
            if (rx_done) rx_done_cnt++;
            if (busy_window && eng_ready != 0) busy_violation = 1'b1;
            for (int i = 0; i < N_ENG; i++) begin
                if (eng_ready[i] && !prev_ready[i]) begin
                    rise_cyc[i] = cyc;
                    if (first_rise_pending) begin
                        offer_lat = cyc - rx_cyc;
                        first_rise_pending = 1'b0;
                    end
                    check("eng_ready_onehot", $countones(eng_ready), 1);
                    check("rx_read_addr_mux", 32'(rx_read_addr), i*100 + 5);
                    if (exp_offer_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL offer_unexpected: got offer to engine %0d, required none (cycle %0d)", i, cyc);
                    end else begin
                        check("offer_order", i, exp_offer_q.pop_front());
                    end
                end
                if (!eng_ready[i] && prev_ready[i] && cfg_mode[i] == M_HANG) begin
                    check("hang_hold_cycles", cyc - rise_cyc[i], TIMEOUT + 1);
                end
            end
            prev_ready = eng_ready;
        end
    end

    task automatic run_packet(input vec_t v);
        int guard;
        cfg_mode[0] = v.m0; cfg_mode[1] = v.m1; cfg_mode[2] = v.m2;
        cfg_dly = v.dly; cfg_stray = v.stray;
        for (int k = 0; k < v.n_off; k++) exp_offer_q.push_back(k);
        tx_start_cnt = 0; rx_done_cnt = 0; offer_lat = -1; busy_violation = 1'b0;
        if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'(v.drop_inc);
        exp_to = exp_to | v.to;
        @(posedge mac_clk); #1;
        rx_ready = 1'b1;
        if (v.busy > 0) begin
            tx_busy = 1'b1;
            busy_window = 1'b1;
            repeat (v.busy) begin @(posedge mac_clk); #1; end
            busy_window = 1'b0;
            tx_busy = 1'b0;
        end
        rx_cyc = cyc;
        first_rise_pending = 1'b1;
        repeat (3) begin @(posedge mac_clk); #1; end
        rx_ready = 1'b0;
        guard = 0;
        while (rx_done_cnt == 0 && guard < 3000) begin
            @(posedge mac_clk); #1; guard++;
        end
        if (rx_done_cnt == 0) begin
            n_cmp++; n_err++;
            $display("FAIL packet_timeout: got no rx_done within %0d cycles, required one", guard);
        end
        repeat (5) begin @(posedge mac_clk); #1; end
        check("offer_latency", offer_lat, 2);
        check("offers_left", exp_offer_q.size(), 0);
        check("tx_writes_left", tx_q.size(), 0);
        check("tx_start_count", tx_start_cnt, v.n_tx);
        check("rx_done_count", rx_done_cnt, 1);
        check("drop_count", 32'(drop_count), 32'(exp_drop));
        check("timeout_seen", 32'(timeout_seen), 32'(exp_to));
        if (v.busy > 0) check("offer_during_tx_busy", 32'(busy_violation), 0);
    endtask

    initial begin
        int guard;
        vecs[0] = '{M_REP,  M_DEC,  M_DEC,  50, 0,   1'b0, 1, 1, 0, 1'b0};
        vecs[1] = '{M_DEC,  M_DEC,  M_REP,  3,  0,   1'b0, 3, 1, 0, 1'b0};
        vecs[2] = '{M_DEC,  M_DEC,  M_DEC,  2,  0,   1'b0, 3, 0, 1, 1'b0};
        vecs[3] = '{M_DEC,  M_HANG, M_REP,  3,  0,   1'b0, 3, 1, 0, 1'b1};
        vecs[4] = '{M_REP,  M_DEC,  M_DEC,  10, 100, 1'b1, 1, 1, 0, 1'b0};
        vecs[5] = '{M_DEC,  M_REP,  M_DEC,  4,  0,   1'b0, 2, 1, 0, 1'b0};
        vecs[6] = '{M_DEC,  M_HANG, M_DEC,  1,  0,   1'b0, 3, 0, 1, 1'b1};
        for (int i = 0; i < N_ENG; i++) cfg_mode[i] = M_DEC;
        cfg_dly = 0; cfg_stray = 1'b0;

        repeat (3) begin @(posedge mac_clk); #1; end
        check_all_zero("reset");
        reset = 1'b0;
        exp_drop = 16'd0;
        exp_to = 1'b0;

        for (int v = 0; v < 7; v++) run_packet(vecs[v]);

        // Reset asserted while engine 0 is streaming into the tx buffer
        cfg_mode[0] = M_STREAM; cfg_dly = 2; cfg_stray = 1'b0;
        exp_offer_q.push_back(0);
        @(posedge mac_clk); #1;
        rx_ready = 1'b1;
        @(posedge mac_clk); #1;
        rx_ready = 1'b0;
        guard = 0;
        do begin
            @(posedge mac_clk); #2; guard++;
        end while (!tx_we && guard < 100);
        check("stream_tx_we_seen", 32'(tx_we), 1);
        #1 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(posedge mac_clk); #1;
        reset = 1'b0;
        @(posedge mac_clk); #2;
        tx_q.delete();
        exp_offer_q.delete();
        exp_drop = 16'd0;
        exp_to = 1'b0;
        run_packet('{M_REP, M_DEC, M_DEC, 5, 0, 1'b0, 1, 1, 0, 1'b0});

        // Saturation: preload the counter, then an all-decline packet must leave it pinned
        force dut.drop_count = 16'hFFFF;
        @(posedge mac_clk); #1;
        release dut.drop_count;
        @(posedge mac_clk); #1;
        check("drop_preload", 32'(drop_count), 32'hFFFF);
        exp_drop = 16'hFFFF;
        run_packet(vecs[2]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test by %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
